// File: rtl/secuenciador_programa_if.sv
// secuenciador_programa_if: sequencer bus bundling program-memory fetch, jump-block and datapath signals
interface secuenciador_programa_if #(parameter int ADDR_W = 11);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              mem_ready;
  logic [15:0]       ir;
  logic              pre_load;
  logic              exec_en;
  logic              dp_busy;
  logic              run;
  logic              halted;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       retired;
  modport master (
    output mem_req, mem_addr, ir, exec_en, halted, pc, retired,
    input  mem_data, mem_ready, pre_load, dp_busy, run
  );
  modport slave (
    input  mem_req, mem_addr, ir, exec_en, halted, pc, retired,
    output mem_data, mem_ready, pre_load, dp_busy, run
  );
endinterface

// File: rtl/secuenciador_programa.sv
// secuenciador_programa: owns PC and IR, fetches over a req/ready handshake,
// redirects on jump decisions, strobes the datapath and halts on HALT.
module secuenciador_programa #(
  parameter int                ADDR_W       = 11,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input logic                     clk,
  input logic                     rst_n,
  secuenciador_programa_if.master bus
);
  typedef enum logic [2:0] {S_WAIT, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;
  state_t            r_state;
  logic              r_armed;
  logic              r_mem_req;
  logic              r_exec_en;
  logic              r_halted;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_ir;
  logic [15:0]       r_retired;
  logic              w_halt_op;
  assign w_halt_op = r_ir[15:14] == 2'b11 && !r_ir[13];
  // WAIT spans one full clock after the asynchronous release, so the first
  // fetch request appears on the second rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_WAIT;
      r_armed   <= 1'b0;
      r_mem_req <= 1'b0;
      r_exec_en <= 1'b0;
      r_halted  <= 1'b0;
      r_pc      <= RESET_VECTOR;
      r_ir      <= 16'h0000;
      r_retired <= 16'h0000;
    end else begin
      case (r_state)
        S_WAIT: begin
          r_armed <= 1'b1;
          if (r_armed) begin
            r_state   <= S_FETCH;
            r_mem_req <= 1'b1;
          end
        end
        S_FETCH: if (bus.mem_ready) begin
          r_ir      <= bus.mem_data;
          r_pc      <= r_pc + ADDR_W'(1);
          r_state   <= S_DECODE;
          r_mem_req <= 1'b0;
        end
        S_DECODE: if (w_halt_op) begin
          r_state   <= S_HALT;
          r_halted  <= 1'b1;
          r_retired <= r_retired + 16'd1;
        end else begin
          r_state   <= S_EXEC;
          r_exec_en <= !r_ir[13];
        end
        S_EXEC: begin
          r_exec_en <= 1'b0;
          if (r_ir[13] || !bus.dp_busy) begin
            if (r_ir[13] && bus.pre_load) r_pc <= r_ir[ADDR_W-1:0];
            r_retired <= r_retired + 16'd1;
            r_state   <= S_FETCH;
            r_mem_req <= 1'b1;
          end
        end
        S_HALT: if (bus.run) begin
          r_state   <= S_FETCH;
          r_halted  <= 1'b0;
          r_mem_req <= 1'b1;
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end
  assign bus.mem_req  = r_mem_req;
  assign bus.mem_addr = r_pc;
  assign bus.ir       = r_ir;
  assign bus.exec_en  = r_exec_en;
  assign bus.halted   = r_halted;
  assign bus.pc       = r_pc;
  assign bus.retired  = r_retired;
endmodule

// File: tb/tb_secuenciador_programa.sv
// tb_secuenciador_programa: directed program run with a fetch/exec scoreboard
// plus timing, halt, wrap and asynchronous-reset checks.
module tb_secuenciador_programa;
  logic clk = 1'b0;
  logic rst_n;
  logic late;
  int   errors = 0;
  int   checks = 0;
  int   wcnt;
  int   bcnt;
  logic [15:0] mem [0:2047];
  logic [10:0] fq [$];
  logic [15:0] eq [$];

  secuenciador_programa_if #(.ADDR_W(11)) bus ();
  secuenciador_programa #(.ADDR_W(11), .RESET_VECTOR(11'd0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [10:0] a);
    return (a == 11'h041) ? 2 : ((a == 11'h7FF && late) ? 4 : 0);
  endfunction

  function automatic bit cond(input int k);
    case (k)
      0: return bus.exec_en && bus.ir == 16'h4003;
      1: return bus.mem_req && bus.mem_addr == 11'h041;
      2: return bus.halted;
      3: return bus.exec_en && bus.ir == 16'h0005;
      4: return bus.mem_req && bus.mem_addr == 11'h7FF && late;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int k, input string name);
    int n = 0;
    while (!cond(k) && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    check({name, "_reached"}, 32'(n < 500), 32'd1);
  endtask

  // Memory, datapath and jump-block stand-ins; the jump block takes a jump iff B11=0.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_data  = 16'h0000;
    bus.dp_busy   = 1'b0;
    bus.pre_load  = 1'b0;
    wcnt = 0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        bus.mem_ready = wcnt >= lat_of(bus.mem_addr);
        bus.mem_data  = bus.mem_ready ? mem[bus.mem_addr] : 16'hDEAD;
        wcnt++;
      end else begin
        bus.mem_ready = 1'b0;
        wcnt = 0;
      end
      if (bus.exec_en) bcnt = (bus.ir == 16'h4003) ? 3 : 0;
      bus.dp_busy = bcnt > 0;
      if (bcnt > 0) bcnt--;
      bus.pre_load = bus.ir[13] & ~bus.ir[11];
    end
  end

  initial begin
    forever begin
      @(negedge clk); #1;
      if (rst_n && bus.mem_req && bus.mem_ready) begin
        if (fq.size() == 0) check("fetch_unexpected", 32'(bus.mem_addr), 32'hFFFF);
        else check("fetch_addr", 32'(bus.mem_addr), 32'(fq.pop_front()));
      end
      if (rst_n && bus.exec_en) begin
        if (eq.size() == 0) check("exec_unexpected", 32'(bus.ir), 32'hFFFF_FFFF);
        else check("exec_ir", 32'(bus.ir), 32'(eq.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    int  extra;
    bit  bad;
    rst_n   = 1'b0;
    bus.run = 1'b0;
    late    = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0001;
    mem[1]      = 16'h0002;
    mem[2]      = 16'h4003;
    mem[3]      = 16'h2005;
    mem[4]      = 16'hFFFF;
    mem[5]      = 16'h2040;
    mem['h40]   = 16'h2840;
    mem['h41]   = 16'h0007;
    mem['h42]   = 16'h2007;
    mem[7]      = 16'hC000;
    mem[8]      = 16'h27FF;
    mem['h7FF]  = 16'h0005;
    fq = '{11'h000, 11'h001, 11'h002, 11'h003, 11'h005, 11'h040, 11'h041, 11'h042,
           11'h007, 11'h008, 11'h7FF, 11'h000};
    eq = '{16'h0001, 16'h0002, 16'h4003, 16'h0007, 16'h0005};
    #2;
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_exec_en", 32'(bus.exec_en), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_pc", 32'(bus.pc), 32'd0);
    check("rst_ir", 32'(bus.ir), 32'd0);
    check("rst_retired", 32'(bus.retired), 32'd0);
    #20 rst_n = 1'b1;
    @(negedge clk); #1;
    check("wait_no_req", 32'(bus.mem_req), 32'd0);
    @(negedge clk); #1;
    check("first_req", 32'(bus.mem_req), 32'd1);
    check("first_addr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk); #1;
    check("decode_no_exec_en", 32'(bus.exec_en), 32'd0);
    @(negedge clk); #1;
    check("exec_en_cycle4", 32'(bus.exec_en), 32'd1);
    @(negedge clk); #1;
    check("second_req", 32'(bus.mem_req), 32'd1);
    check("second_addr", 32'(bus.mem_addr), 32'd1);
    check("retired_1", 32'(bus.retired), 32'd1);
    check("exec_en_drop", 32'(bus.exec_en), 32'd0);
    mem[0] = 16'h27FF;
    wait_for(0, "busy_exec");
    cyc   = 1;
    extra = 0;
    while (!bus.mem_req && cyc < 20) begin
      @(negedge clk); #1;
      if (bus.exec_en) extra++;
      cyc++;
    end
    check("busy_exec_len", 32'(cyc - 1), 32'd4);
    check("busy_exec_en_width", 32'(extra), 32'd0);
    wait_for(1, "slow_fetch");
    bus.run = 1'b1;
    @(negedge clk); #1;
    bus.run = 1'b0;
    @(negedge clk); #1;
    check("run_in_fetch_ignored", 32'(bus.halted), 32'd0);
    wait_for(2, "halt");
    check("halt_pc", 32'(bus.pc), 32'd8);
    check("halt_retired", 32'(bus.retired), 32'd9);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (bus.mem_req || !bus.halted || bus.pc != 11'd8) bad = 1'b1;
    end
    check("halt_hold", 32'(bad), 32'd0);
    bus.run = 1'b1;
    @(negedge clk); #1;
    bus.run = 1'b0;
    check("resume_req", 32'(bus.mem_req), 32'd1);
    check("resume_addr", 32'(bus.mem_addr), 32'd8);
    check("resume_halted", 32'(bus.halted), 32'd0);
    wait_for(3, "wrap_exec");
    check("wrap_pc", 32'(bus.pc), 32'd0);
    check("wrap_retired", 32'(bus.retired), 32'd10);
    late = 1'b1;
    wait_for(4, "late_fetch");
    repeat (2) begin
      @(negedge clk); #1;
    end
    check("late_still_waiting", 32'(bus.mem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_mem_req", 32'(bus.mem_req), 32'd0);
    check("abort_pc", 32'(bus.pc), 32'd0);
    check("abort_ir", 32'(bus.ir), 32'd0);
    check("abort_retired", 32'(bus.retired), 32'd0);
    check("abort_halted", 32'(bus.halted), 32'd0);
    check("fetch_queue_drained", 32'(fq.size()), 32'd0);
    check("exec_queue_drained", 32'(eq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
